// File: rtl/sr_bank_preset_seq.sv
// Preset sequencer for a bank of async set/reset flops: gates the bank clock,
// pulses per-bit SETN/RN, waits for recovery, verifies readback, then ungates.
module sr_bank_preset_seq #(
  parameter int W         = 8,
  parameter int GATE_CYC  = 1,
  parameter int PULSE_CYC = 2,
  parameter int REC_CYC   = 2,
  parameter int MAX_RETRY = 1
) (
  input  logic         CLK,
  input  logic         RN,
  input  logic         start,
  input  logic [W-1:0] preset_val,
  input  logic [W-1:0] preset_mask,
  input  logic [W-1:0] bank_q,
  output logic [W-1:0] bank_setn,
  output logic [W-1:0] bank_rn,
  output logic         bank_clk_en,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int MAX_GP = (GATE_CYC > PULSE_CYC) ? GATE_CYC : PULSE_CYC;
  localparam int MAX_C  = (MAX_GP > REC_CYC) ? MAX_GP : REC_CYC;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] GATE_LD   = CW'(GATE_CYC);
  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC);
  localparam logic [CW-1:0] REC_LD    = CW'(REC_CYC);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [2:0]    RETRY_LIM = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATE,
    S_ASSERT,
    S_RELEASE,
    S_CHECK,
    S_UNGATE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    retry_q, retry_d;
  logic [W-1:0]  val_q, val_d;
  logic [W-1:0]  mask_q, mask_d;
  logic          pass_q, pass_d;
  logic          error_q, error_d;

  logic [W-1:0]  setn_q, setn_d;
  logic [W-1:0]  rn_q, rn_d;
  logic          clk_en_q, clk_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          mismatch;
  logic          drive_d;

  assign mismatch = |((bank_q ^ val_q) & mask_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    val_d   = val_q;
    mask_d  = mask_q;
    pass_d  = pass_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          val_d   = preset_val;
          mask_d  = preset_mask;
          error_d = 1'b0;
          retry_d = 3'd0;
          pass_d  = 1'b0;
          cnt_d   = GATE_LD;
          state_d = S_GATE;
        end
      end
      S_GATE: begin
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = PULSE_LD;
          state_d = S_ASSERT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_ASSERT: begin
        if (cnt_q <= CNT_ONE) begin
          cnt_d   = REC_LD;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_RELEASE: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_CHECK: begin
        if (!mismatch) begin
          pass_d  = 1'b1;
          state_d = S_UNGATE;
        end else if (retry_q < RETRY_LIM) begin
          // Retry re-pulses without ungating; the bank never sees a clock edge.
          retry_d = retry_q + 3'd1;
          cnt_d   = PULSE_LD;
          state_d = S_ASSERT;
        end else begin
          pass_d  = 1'b0;
          error_d = 1'b1;
          state_d = S_UNGATE;
        end
      end
      S_UNGATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  assign drive_d  = (state_d == S_ASSERT);
  assign clk_en_d = (state_d == S_IDLE) || (state_d == S_UNGATE);
  assign busy_d   = (state_d != S_IDLE);
  assign done_d   = (state_q == S_UNGATE) && pass_q;

  // SETN needs val=1 and RN needs val=0, so a bit can never have both low.
  for (genvar gi = 0; gi < W; gi++) begin : g_pin
    assign setn_d[gi] = ~(drive_d & mask_d[gi] &  val_d[gi]);
    assign rn_d[gi]   = ~(drive_d & mask_d[gi] & ~val_d[gi]);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      retry_q  <= 3'd0;
      val_q    <= '0;
      mask_q   <= '0;
      pass_q   <= 1'b0;
      error_q  <= 1'b0;
      setn_q   <= '1;
      rn_q     <= '1;
      clk_en_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      retry_q  <= retry_d;
      val_q    <= val_d;
      mask_q   <= mask_d;
      pass_q   <= pass_d;
      error_q  <= error_d;
      setn_q   <= setn_d;
      rn_q     <= rn_d;
      clk_en_q <= clk_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bank_setn   = setn_q;
  assign bank_rn     = rn_q;
  assign bank_clk_en = clk_en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_sr_bank_preset_seq.sv
// Directed bench for sr_bank_preset_seq with a behavioural async set/reset bank
// model (optional stuck-at-0 bits) and a per-cycle SETN/RN exclusivity check.
module tb_sr_bank_preset_seq;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RN = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] preset_val = '0;
  logic [W-1:0] preset_mask = '0;
  logic [W-1:0] bank_q;
  logic [W-1:0] bank_setn, bank_rn;
  logic         bank_clk_en, busy, done, error;

  int total = 0;
  int bad = 0;

  logic [W-1:0] bank_state = '0;
  logic [W-1:0] stuck0 = '0;
  logic [W-1:0] load_val = '0;
  bit           load_req = 1'b0;
  bit           load_seen = 1'b0;

  int n_pat, n_phase, n_gate, n_done, done_at, n_idle, n_rnlow;

  always #5 CLK = ~CLK;

  sr_bank_preset_seq #(
    .W(W), .GATE_CYC(1), .PULSE_CYC(2), .REC_CYC(2), .MAX_RETRY(1)
  ) dut (
    .CLK(CLK), .RN(RN), .start(start),
    .preset_val(preset_val), .preset_mask(preset_mask), .bank_q(bank_q),
    .bank_setn(bank_setn), .bank_rn(bank_rn), .bank_clk_en(bank_clk_en),
    .busy(busy), .done(done), .error(error)
  );

  // Bank model: async set dominates, then async reset; preload via load_req toggle.
  always @(bank_setn or bank_rn or load_req) begin
    if (load_req !== load_seen) begin
      bank_state = load_val;
      load_seen  = load_req;
    end
    for (int i = 0; i < W; i++) begin
      if (bank_setn[i] === 1'b0)    bank_state[i] = 1'b1;
      else if (bank_rn[i] === 1'b0) bank_state[i] = 1'b0;
    end
  end
  assign bank_q = bank_state & ~stuck0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    total++;
    assert ((~bank_setn & ~bank_rn) === '0) else begin
      bad++;
      $error("FAIL invariant observed setn=%h rn=%h expected no shared zero", bank_setn, bank_rn);
    end
  endtask

  task automatic load_bank(input logic [W-1:0] v);
    load_val = v;
    load_req = ~load_req;
    #1;
  endtask

  task automatic run(input logic [W-1:0] v, input logic [W-1:0] m, input int n,
                     input bit hold, input logic [W-1:0] es, input logic [W-1:0] er);
    bit prev;
    preset_val = v;
    preset_mask = m;
    start = 1'b1;
    n_pat = 0; n_phase = 0; n_gate = 0; n_done = 0; done_at = -1; n_idle = 0; n_rnlow = 0;
    prev = 1'b0;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (!hold) begin
        start = 1'b0;
        preset_val = ~v;
        preset_mask = ~m;
      end
      if (bank_setn === es && bank_rn === er) begin
        n_pat++;
        if (!prev) n_phase++;
        prev = 1'b1;
      end else begin
        prev = 1'b0;
      end
      if (bank_clk_en === 1'b0) n_gate++;
      if (bank_rn !== 8'hFF) n_rnlow++;
      if (busy === 1'b0) n_idle++;
      if (done === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = t;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int act;
    // Reset state
    tick(); tick();
    chk("rst_setn", 32'(bank_setn), 32'hFF);
    chk("rst_rn", 32'(bank_rn), 32'hFF);
    chk("rst_clk_en", 32'(bank_clk_en), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
    RN = 1'b1;
    tick();

    // Full preset A5/FF from a cleared bank
    load_bank(8'h00);
    run(8'hA5, 8'hFF, 10, 1'b0, 8'h5A, 8'hA5);
    chk("t1_pulse_cycles", 32'(n_pat), 32'd2);
    chk("t1_gated_cycles", 32'(n_gate), 32'd6);
    chk("t1_done_latency", 32'(done_at), 32'd8);
    chk("t1_done_count", 32'(n_done), 32'd1);
    chk("t1_error", 32'(error), 32'h0);
    chk("t1_bank_q", 32'(bank_q), 32'hA5);
    chk("t1_busy", 32'(busy), 32'h0);

    // Partial mask: only low nibble set, RN never asserted
    load_bank(8'h00);
    run(8'hFF, 8'h0F, 10, 1'b0, 8'hF0, 8'hFF);
    chk("t2_setn_cycles", 32'(n_pat), 32'd2);
    chk("t2_rn_low_cycles", 32'(n_rnlow), 32'd0);
    chk("t2_bank_q", 32'(bank_q), 32'h0F);
    chk("t2_done_count", 32'(n_done), 32'd1);

    // Stuck bit: one retry, then sticky error
    load_bank(8'h00);
    stuck0 = 8'h04;
    run(8'h04, 8'hFF, 16, 1'b0, 8'hFB, 8'h04);
    chk("t3_assert_cycles", 32'(n_pat), 32'd4);
    chk("t3_assert_phases", 32'(n_phase), 32'd2);
    chk("t3_done_count", 32'(n_done), 32'd0);
    chk("t3_error", 32'(error), 32'h1);
    chk("t3_clk_en", 32'(bank_clk_en), 32'h1);
    chk("t3_busy", 32'(busy), 32'h0);
    tick(); tick();
    chk("t3_error_sticky", 32'(error), 32'h1);
    stuck0 = 8'h00;
    preset_val = 8'h04; preset_mask = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t3_error_cleared", 32'(error), 32'h0);
    act = 0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (done === 1'b1) act++;
    end
    chk("t3_rerun_done", 32'(act), 32'd1);
    chk("t3_rerun_bank_q", 32'(bank_q), 32'h04);

    // Reset during ASSERT
    load_bank(8'h00);
    preset_val = 8'hA5; preset_mask = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t4_assert_rn", 32'(bank_rn), 32'hA5);
    chk("t4_assert_setn", 32'(bank_setn), 32'h5A);
    RN = 1'b0;
    #1;
    chk("t4_rst_setn", 32'(bank_setn), 32'hFF);
    chk("t4_rst_rn", 32'(bank_rn), 32'hFF);
    chk("t4_rst_clk_en", 32'(bank_clk_en), 32'h1);
    chk("t4_rst_busy", 32'(busy), 32'h0);
    tick();
    RN = 1'b1;
    act = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (busy !== 1'b0 || bank_setn !== 8'hFF || bank_rn !== 8'hFF || bank_clk_en !== 1'b1) act++;
    end
    chk("t4_no_activity", 32'(act), 32'd0);

    // start held high: back-to-back runs, one idle (done) cycle between
    run(8'h3C, 8'hFF, 40, 1'b1, 8'hC3, 8'h3C);
    chk("t5_done_count", 32'(n_done), 32'd5);
    chk("t5_idle_cycles", 32'(n_idle), 32'd5);
    chk("t5_first_done", 32'(done_at), 32'd8);

    // start pulsed while busy is ignored
    preset_val = 8'h81; preset_mask = 8'hFF; start = 1'b1;
    act = 0;
    for (int t = 1; t <= 16; t++) begin
      tick();
      start = (t == 2) ? 1'b1 : 1'b0;
      if (done === 1'b1) act++;
    end
    chk("t5_busy_start_ignored", 32'(act), 32'd1);
    chk("t5_busy_bank_q", 32'(bank_q), 32'h81);

    // Random stress; exclusivity checked every cycle inside tick()
    for (int t = 0; t < 10000; t++) begin
      tick();
      start = 1'($urandom_range(0, 1));
      preset_val = 8'($urandom);
      preset_mask = 8'($urandom);
      RN = ($urandom_range(0, 63) != 0);
    end
    RN = 1'b1;
    start = 1'b0;
    for (int t = 0; t < 30; t++) tick();
    chk("t6_settled_busy", 32'(busy), 32'h0);
    chk("t6_settled_clk_en", 32'(bank_clk_en), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
